instr_fetch: RTL and testbench

- Front end of the SIMPLE 16-bit core.
- Fetches instruction words from instruction memory over a req/ack handshake.
- Buffers up to two words with their PCs and presents them to the decode/control stage through a valid/ready interface.
- Consumes that stage's branch decision (PCSrc plus target) as a redirect. Stops fetching after an HLT and restarts on exec.

---
 rtl/simple_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared ISA definitions for the SIMPLE 16-bit core: widths, opcode fields,
// fetch state encoding and the HLT decode helper.
package simple_pkg;

  localparam int ISA_ADDR_W = 16;
  localparam int ISA_DATA_W = 16;

  // Major opcode lives in [15:14]; ALU sub-opcode lives in [7:4].
  localparam logic [1:0] OP1_LD  = 2'b00;
  localparam logic [1:0] OP1_BR  = 2'b10;
  localparam logic [1:0] OP1_ALU = 2'b11;
  localparam logic [3:0] OP3_CMP = 4'b0101;
  localparam logic [3:0] OP3_OUT = 4'b1101;
  localparam logic [3:0] OP3_HLT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_hlt(input logic [ISA_DATA_W-1:0] word);
    return (word[15:14] == OP1_ALU) && (word[7:4] == OP3_HLT);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, word} prefetch buffer. Entry 0 is always the head; when the
// buffer drains, the head registers keep their last contents.
module fetch_fifo #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_word,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_word,
  output logic [1:0]        count
);

  logic [ADDR_W-1:0] pc0, pc1;
  logic [DATA_W-1:0] w0, w1;
  logic              pop_ok;

  assign pop_ok    = pop && (count != 2'd0);
  assign head_pc   = pc0;
  assign head_word = w0;

  // Entry storage and occupancy; flush discards everything, including a
  // coincident push or pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc0   <= '0;
      pc1   <= '0;
      w0    <= '0;
      w1    <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      assert (!(push && !pop_ok && (count == 2'd2)));
      case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            pc0 <= push_pc;
            w0  <= push_word;
          end else begin
            pc1 <= push_pc;
            w1  <= push_word;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            pc0 <= pc1;
            w0  <= w1;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            pc0 <= pc1;
            w0  <= w1;
            pc1 <= push_pc;
            w1  <= push_word;
          end else begin
            pc0 <= push_pc;
            w0  <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues one outstanding imem request at a time,
// buffers up to two fetched words, handles branch redirects and HLT/resume.
//
// state | meaning
// IDLE  | out of reset, waiting for exec
// RUN   | fetching and feeding decode
// HALT  | HLT retired, waiting for exec to resume after it
module instr_fetch
  import simple_pkg::*;
#(
  parameter int ADDR_W = ISA_ADDR_W,
  parameter int DATA_W = ISA_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              halted
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  fetch_state_e state, state_next;

  logic [ADDR_W-1:0] fetch_pc, pc_next, addr_next;
  logic              drop, drop_next;
  logic              stop, stop_next;
  logic              req_next;
  logic              ack_fire, push, pop, flush, redir_eff;
  logic              outstanding_after;
  logic [2:0]        count_after;
  logic [1:0]        count;

  assign instr_valid = (count != 2'd0);
  assign halted      = (state == HALT);

  assign redir_eff = redirect && (state == RUN);
  assign ack_fire  = imem_req && imem_ack;
  assign push      = ack_fire && !drop && !redir_eff;
  assign pop       = instr_valid && instr_ready;
  assign flush     = redir_eff;

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_pc   (imem_addr),
    .push_word (imem_rdata),
    .pop       (pop),
    .flush     (flush),
    .head_pc   (pc_out),
    .head_word (instr),
    .count     (count)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: a retired HLT halts unless a redirect in the same cycle
  // reopens the stream.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (exec) state_next = RUN;
      RUN:     if (pop && is_hlt(instr) && !redir_eff) state_next = HALT;
      HALT:    if (exec) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Fetch bookkeeping: next PC, drop/stop flags and the registered request.
  // A request may re-issue on the edge that retires the previous ack, using
  // the post-edge occupancy so buffer + in-flight never exceeds DEPTH.
  always_comb begin
    pc_next           = fetch_pc;
    drop_next         = drop;
    stop_next         = stop;
    outstanding_after = imem_req && !imem_ack;

    if (redir_eff) begin
      pc_next   = redirect_target;
      drop_next = outstanding_after;
    end else begin
      if (ack_fire && !drop) pc_next = imem_addr + ADDR_W'(1);
      if (ack_fire)          drop_next = 1'b0;
    end

    if (redir_eff || ((state == HALT) && exec)) stop_next = 1'b0;
    else if (push && is_hlt(imem_rdata))        stop_next = 1'b1;

    if (flush) count_after = 3'd0;
    else       count_after = {1'b0, count} + {2'b00, push} - {2'b00, pop};

    req_next  = outstanding_after ||
                ((state_next == RUN) && !stop_next && (count_after < DEPTH_L));
    addr_next = outstanding_after ? imem_addr : pc_next;
  end

  // Fetch registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= '0;
      drop      <= 1'b0;
      stop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      fetch_pc  <= pc_next;
      drop      <= drop_next;
      stop      <= stop_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: linear cycle-by-cycle script with a simple
// latency-programmable instruction memory responder folded into each step.
module tb_instr_fetch;

  logic        clock;
  logic        reset;
  logic        exec;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        halted;

  int total;
  int bad;
  int mem_lat;
  int wait_cnt;

  instr_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .exec            (exec),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halted          (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory image: HLT at address 3, otherwise word = address + 1.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == 16'd3) w = 16'hC0F0;
    else            w = a + 16'd1;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then decide this cycle's memory response: ack once the
  // current request has been held for mem_lat cycles.
  task automatic step();
    @(posedge clock);
    #1;
    if (imem_req) begin
      if (wait_cnt == mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    mem_lat = 1;
    wait_cnt = 0;
    reset = 1'b0;
    exec = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = 16'h0000;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;

    step();
    step();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", pc_out, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);

    reset = 1'b1;
    step();
    step();
    check("idle_no_req", imem_req, 0);

    // Start: first request one cycle after exec.
    exec = 1'b1;
    step();
    exec = 1'b0;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 16'h0000);
    check("first_valid", instr_valid, 0);
    step();
    check("ack_cycle_valid", instr_valid, 0);
    step();
    check("first_word_valid", instr_valid, 1);
    check("first_word_instr", instr, 16'h0001);
    check("first_word_pc", pc_out, 16'h0000);
    check("second_req", imem_req, 1);
    check("second_addr", imem_addr, 16'h0001);
    step();
    step();
    check("full_req_low", imem_req, 0);
    check("full_valid", instr_valid, 1);

    // Decode stalled: buffer holds 0x0001, 0x0002 and fetching stops.
    repeat (10) step();
    check("stall_req_low", imem_req, 0);
    check("stall_head_instr", instr, 16'h0001);
    check("stall_head_pc", pc_out, 16'h0000);

    instr_ready = 1'b1;
    step();
    check("drain_instr", instr, 16'h0002);
    check("drain_pc", pc_out, 16'h0001);
    check("refill_req", imem_req, 1);
    check("refill_addr", imem_addr, 16'h0002);
    step();
    check("drain_empty", instr_valid, 0);
    step();
    check("word3_instr", instr, 16'h0003);
    check("word3_pc", pc_out, 16'h0002);
    check("hlt_fetch_addr", imem_addr, 16'h0003);
    check("hlt_fetch_req", imem_req, 1);
    step();
    step();
    check("hlt_head_instr", instr, 16'hC0F0);
    check("hlt_head_pc", pc_out, 16'h0003);
    check("hlt_no_fetch", imem_req, 0);
    step();
    check("halted_set", halted, 1);
    check("halted_empty", instr_valid, 0);
    check("halted_no_fetch", imem_req, 0);
    check("halted_hold_pc", pc_out, 16'h0003);
    step();
    step();
    check("halt_stays_req", imem_req, 0);
    check("halt_stays", halted, 1);

    // Resume after HLT at the following word.
    exec = 1'b1;
    step();
    exec = 1'b0;
    instr_ready = 1'b0;
    check("resume_req", imem_req, 1);
    check("resume_addr", imem_addr, 16'h0004);
    check("resume_halted", halted, 0);
    step();
    mem_lat = 3;
    step();
    check("word5_instr", instr, 16'h0005);
    check("word5_pc", pc_out, 16'h0004);
    check("addr5_req", imem_req, 1);
    check("addr5_addr", imem_addr, 16'h0005);

    // Redirect while addr 5 is in flight: flush, drop the late word.
    redirect = 1'b1;
    redirect_target = 16'h0040;
    step();
    redirect = 1'b0;
    check("redir_flush", instr_valid, 0);
    check("redir_hold_req", imem_req, 1);
    check("redir_hold_addr", imem_addr, 16'h0005);
    step();
    step();
    mem_lat = 1;
    step();
    check("dropped_not_pushed", instr_valid, 0);
    check("target_req", imem_req, 1);
    check("target_addr", imem_addr, 16'h0040);
    step();
    step();
    check("target_valid", instr_valid, 1);
    check("target_pc", pc_out, 16'h0040);
    check("target_instr", instr, 16'h0041);
    check("target_next_addr", imem_addr, 16'h0041);

    // Redirect in the same cycle as an ack: word 0x0042 is discarded.
    step();
    redirect = 1'b1;
    redirect_target = 16'hFFFF;
    step();
    redirect = 1'b0;
    check("coinc_flush", instr_valid, 0);
    check("coinc_req", imem_req, 1);
    check("coinc_addr", imem_addr, 16'hFFFF);
    step();
    step();
    check("wrap_valid", instr_valid, 1);
    check("wrap_instr", instr, 16'h0000);
    check("wrap_pc", pc_out, 16'hFFFF);
    check("wrap_req", imem_req, 1);
    check("wrap_addr", imem_addr, 16'h0000);

    // Asynchronous reset with a fetch in flight.
    reset = 1'b0;
    #1;
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_instr", instr, 0);
    check("mid_rst_pc", pc_out, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_halted", halted, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
